// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 7:1 mux scan controller.
package mux_scan_pkg;

    localparam int unsigned NCH      = 7;
    localparam int unsigned SEL_W    = 3;
    localparam logic [NCH-1:0] MASK_ALL = 7'h7F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/chan_next_find.sv
// Combinational search for the next enabled channel above sel_i,
// or the lowest enabled channel when first_i is set.
module chan_next_find
    import mux_scan_pkg::*;
(
    input  logic [NCH-1:0]   mask_i,
    input  logic [SEL_W-1:0] sel_i,
    input  logic             first_i,
    output logic [SEL_W-1:0] next_o,
    output logic             found_o
);

    always_comb begin
        next_o  = '0;
        found_o = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!found_o && mask_i[i] && (first_i || (SEL_W'(i) > sel_i))) begin
                next_o  = SEL_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans enabled channels of a downstream 7:1 mux, waiting dwell cycles
// per channel before capturing z into the matching word bit.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [NCH-1:0]     en_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               z,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               done,
    output logic [NCH-1:0]     word,
    output logic               valid
);

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [NCH-1:0]     mask_q, mask_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NCH-1:0]     word_q, word_d;
    logic               valid_q, valid_d;

    logic               first;
    logic [SEL_W-1:0]   next_sel;
    logic               found;

    // In IDLE the search runs on the live mask so the first channel is known at start.
    assign first = (state_q == IDLE);

    chan_next_find u_find (
        .mask_i  (first ? en_mask : mask_q),
        .sel_i   (sel_q),
        .first_i (first),
        .next_o  (next_sel),
        .found_o (found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dwell_q <= '0;
            mask_q  <= '0;
            sel_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        mask_d  = mask_q;
        sel_d   = sel_q;
        word_d  = word_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d  = en_mask;
                    dwell_d = dwell;
                    cnt_d   = dwell;
                    word_d  = '0;
                    valid_d = 1'b0;
                    if (found) begin
                        sel_d   = next_sel;
                        state_d = SETTLE;
                    end else begin
                        valid_d = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else begin
                    word_d[sel_q] = z;
                    if (found) begin
                        sel_d = next_sel;
                        cnt_d = dwell_q;
                    end else begin
                        // valid rises on entry so it is already high during DONE
                        valid_d = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel   = sel_q;
    assign word  = word_q;
    assign valid = valid_q;
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Randomized self-checking bench for mux_scan_ctrl against a channel-sequence model.
module tb_mux_scan_ctrl;

    localparam int unsigned DW = 4;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          start   = 1'b0;
    logic [6:0]    en_mask = '0;
    logic [DW-1:0] dwell   = '0;
    logic          z;
    logic [2:0]    sel;
    logic          busy;
    logic          done;
    logic [6:0]    word;
    logic          valid;

    logic [6:0]    zpat     = '0;
    logic [2:0]    hold_sel = '0;
    int unsigned   vecs     = 0;
    int unsigned   errs     = 0;

    always #5 clk = ~clk;

    // Downstream mux: z reflects the bit of the current pattern chosen by sel.
    assign z = zpat[sel];

    mux_scan_ctrl #(.DWELL_W(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .en_mask (en_mask),
        .dwell   (dwell),
        .z       (z),
        .sel     (sel),
        .busy    (busy),
        .done    (done),
        .word    (word),
        .valid   (valid)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] top_chan(input logic [6:0] m, input logic [2:0] prev);
        logic [2:0] r;
        r = prev;
        for (int i = 0; i < 7; i++) if (m[i]) r = 3'(i);
        return r;
    endfunction

    // Called at a negedge with the DUT in IDLE.
    task automatic run_scan(input logic [6:0] m, input logic [DW-1:0] d, input logic [6:0] zp,
                            input bit hold, input bit scramble);
        int unsigned seq[$];
        int unsigned len;
        bit          drained;
        for (int i = 0; i < 7; i++)
            if (m[i]) for (int j = 0; j <= int'(d); j++) seq.push_back(i);
        len     = seq.size();
        start   = 1'b1;
        en_mask = m;
        dwell   = d;
        zpat    = zp;
        @(posedge clk);
        for (int unsigned k = 1; k <= len; k++) begin
            @(negedge clk);
            check_eq("settle_sel", 32'(sel), seq[k-1]);
            check_eq("settle_busy", 32'(busy), 1);
            check_eq("settle_done", 32'(done), 0);
            check_eq("settle_valid", 32'(valid), 0);
            if (!hold) start = 1'b0;
            if (scramble) begin
                en_mask = 7'($urandom);
                dwell   = DW'($urandom);
            end
        end
        hold_sel = top_chan(m, hold_sel);
        @(negedge clk);
        check_eq("done_pulse", 32'(done), 1);
        check_eq("done_busy", 32'(busy), 1);
        check_eq("done_valid", 32'(valid), 1);
        check_eq("done_word", 32'(word), 32'(zp & m));
        check_eq("done_sel", 32'(sel), 32'(hold_sel));
        if (!hold) start = 1'b0;
        @(negedge clk);
        check_eq("idle_done", 32'(done), 0);
        check_eq("idle_busy", 32'(busy), 0);
        check_eq("idle_valid", 32'(valid), 1);
        check_eq("idle_word", 32'(word), 32'(zp & m));
        check_eq("idle_sel", 32'(sel), 32'(hold_sel));
        if (hold) begin
            // start still high: the relaunch happens only now, out of IDLE
            @(negedge clk);
            check_eq("relaunch_busy", 32'(busy), 1);
            start   = 1'b0;
            drained = 1'b0;
            for (int c = 0; c < 300 && !drained; c++) begin
                @(negedge clk);
                if (!busy) drained = 1'b1;
            end
            check_eq("relaunch_drain", 32'(drained), 1);
            hold_sel = top_chan(en_mask, hold_sel);
            check_eq("relaunch_word", 32'(word), 32'(zpat & en_mask));
            check_eq("relaunch_sel", 32'(sel), 32'(hold_sel));
        end
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_sel", 32'(sel), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_word", 32'(word), 0);
        check_eq("rst_valid", 32'(valid), 0);
        rst_n = 1'b1;

        run_scan(7'h7F, 4'd0, 7'b1010110, 1'b0, 1'b0);
        run_scan(7'b1000101, 4'd2, 7'h7F, 1'b0, 1'b0);
        run_scan(7'h00, 4'd3, 7'($urandom), 1'b0, 1'b0);
        run_scan(7'h01, 4'd15, 7'h01, 1'b0, 1'b0);
        run_scan(7'b0110110, 4'd1, 7'b0100100, 1'b1, 1'b1);

        // Reset during SETTLE
        start   = 1'b1;
        en_mask = 7'h7F;
        dwell   = 4'd3;
        zpat    = 7'h7F;
        @(posedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("abort_sel", 32'(sel), 0);
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_done", 32'(done), 0);
        check_eq("abort_word", 32'(word), 0);
        check_eq("abort_valid", 32'(valid), 0);
        @(negedge clk);
        check_eq("abort_done_hold", 32'(done), 0);
        rst_n    = 1'b1;
        hold_sel = '0;
        run_scan(7'b0011001, 4'd1, 7'b0010001, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++)
            run_scan(7'($urandom), DW'($urandom_range(0, 3)), 7'($urandom),
                     ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
